// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - shared constants, state encoding and decode helpers for the phase sequencer
//
// Purpose: state encoding, interval-store addresses, lamp encodings and the
//          state-to-output decode functions used by traffic_phase_sequencer.
// Ports:   none (package).
// Config:  TRAFFIC_WALK_REQ_EN only affects reachability of WALK, not this file.
package traffic_pkg;

    localparam logic [1:0] BASE_ADD = 2'b00;
    localparam logic [1:0] EXTD_ADD = 2'b01;
    localparam logic [1:0] YELL_ADD = 2'b10;

    // Store output is registered: value is valid this many cycles after the address moves.
    localparam logic [1:0] LOAD_WAIT = 2'd2;

    localparam logic [2:0] LAMP_R = 3'b100;
    localparam logic [2:0] LAMP_Y = 3'b010;
    localparam logic [2:0] LAMP_G = 3'b001;

    localparam logic [2:0] ST_MAIN_GRN_BASE = 3'd0;
    localparam logic [2:0] ST_MAIN_GRN_EXT  = 3'd1;
    localparam logic [2:0] ST_MAIN_YEL      = 3'd2;
    localparam logic [2:0] ST_WALK          = 3'd3;
    localparam logic [2:0] ST_SIDE_GRN_BASE = 3'd4;
    localparam logic [2:0] ST_SIDE_GRN_EXT  = 3'd5;
    localparam logic [2:0] ST_SIDE_YEL      = 3'd6;

    typedef enum logic [2:0] {
        MAIN_GRN_BASE = ST_MAIN_GRN_BASE,
        MAIN_GRN_EXT  = ST_MAIN_GRN_EXT,
        MAIN_YEL      = ST_MAIN_YEL,
        WALK          = ST_WALK,
        SIDE_GRN_BASE = ST_SIDE_GRN_BASE,
        SIDE_GRN_EXT  = ST_SIDE_GRN_EXT,
        SIDE_YEL      = ST_SIDE_YEL
    } phase_e;

    function automatic logic [1:0] state_addr(input phase_e s);
        logic [1:0] a;
        a = BASE_ADD;
        case (s)
            MAIN_GRN_EXT, WALK, SIDE_GRN_EXT: a = EXTD_ADD;
            MAIN_YEL, SIDE_YEL:               a = YELL_ADD;
            default:                          a = BASE_ADD;
        endcase
        return a;
    endfunction

    // Any state that does not grant the main street shows red on it.
    function automatic logic [2:0] main_lamp(input phase_e s);
        logic [2:0] l;
        l = LAMP_R;
        case (s)
            MAIN_GRN_BASE, MAIN_GRN_EXT: l = LAMP_G;
            MAIN_YEL:                    l = LAMP_Y;
            default:                     l = LAMP_R;
        endcase
        return l;
    endfunction

    function automatic logic [2:0] side_lamp(input phase_e s);
        logic [2:0] l;
        l = LAMP_R;
        case (s)
            SIDE_GRN_BASE, SIDE_GRN_EXT: l = LAMP_G;
            SIDE_YEL:                    l = LAMP_Y;
            default:                     l = LAMP_R;
        endcase
        return l;
    endfunction

endpackage

// File: rtl/phase_timer.sv
// rtl/phase_timer.sv - load-wait counter plus seconds down-counter for one phase
//
// Purpose: after start, waits LOAD_WAIT cycles for the parameter store, loads
//          value (0 becomes 1) and counts down on tick; expired flags the tick
//          that ends the phase.
// Ports:   clk, rst_n      clock, async active-low reset
//          start           (re)arm: clears count, begins load wait; held high keeps it armed
//          value[3:0]      interval from the parameter store
//          tick            1 Hz enable
//          expired         combinational, high on the tick where count==1
module phase_timer
    import traffic_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] value,
    input  logic       tick,
    output logic       expired
);

    logic [1:0] wait_q, wait_d;
    logic       pending_q, pending_d;
    logic [3:0] count_q, count_d;

    // Kept independent of start so the top can feed expired back into start.
    assign expired = tick && !pending_q && (count_q == 4'd1);

    always_comb begin
        wait_d    = wait_q;
        pending_d = pending_q;
        count_d   = count_q;
        if (start) begin
            wait_d    = LOAD_WAIT;
            pending_d = 1'b1;
            count_d   = 4'd0;
        end else if (pending_q) begin
            // Ticks are ignored until the interval has been loaded.
            if (wait_q == 2'd0) begin
                pending_d = 1'b0;
                count_d   = (value == 4'd0) ? 4'd1 : value;
            end else begin
                wait_d = wait_q - 2'd1;
            end
        end else if (tick && (count_q > 4'd1)) begin
            count_d = count_q - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_q    <= LOAD_WAIT;
            pending_q <= 1'b1;
            count_q   <= 4'd0;
        end else begin
            wait_q    <= wait_d;
            pending_q <= pending_d;
            count_q   <= count_d;
        end
    end

endmodule

// File: rtl/traffic_phase_sequencer.sv
// rtl/traffic_phase_sequencer.sv - main/side street phase controller with optional walk phase
//
// Purpose: sequences main/side green-yellow phases, addresses the interval
//          store and drives registered lamp outputs.
// Ports:   clk, sys_reset_n         clock, async active-low reset
//          one_hz_en                1 Hz single-cycle tick
//          sensor_sync              side-street vehicle present
//          prg_sync_in              store reprogramming; forces MAIN_GRN_BASE
//          walk_req_sync            pedestrian request pulse
//          interval_value[3:0]      interval from store (seconds)
//          interval_address[1:0]    address to store
//          main_lights/side_lights  {R,Y,G} one-hot
//          walk_lamp                pedestrian lamp
//          phase_done               one-cycle pulse per timed phase transition
// Config:  TRAFFIC_WALK_REQ_EN enables the walk latch and WALK phase; otherwise
//          walk_req_sync is ignored and walk_lamp is 0.
module traffic_phase_sequencer
    import traffic_pkg::*;
(
    input  logic       clk,
    input  logic       sys_reset_n,
    input  logic       one_hz_en,
    input  logic       sensor_sync,
    input  logic       prg_sync_in,
    input  logic       walk_req_sync,
    input  logic [3:0] interval_value,
    output logic [1:0] interval_address,
    output logic [2:0] main_lights,
    output logic [2:0] side_lights,
    output logic       walk_lamp,
    output logic       phase_done
);

    phase_e     state_q, state_d;
    logic       sens_q, sens_d;
    logic [1:0] addr_q, addr_d;
    logic [2:0] main_q, main_d;
    logic [2:0] side_q, side_d;
    logic       done_q, done_d;
    logic       expired;
    logic       timer_start;

`ifdef TRAFFIC_WALK_REQ_EN
    logic walk_q, walk_d;
    logic walk_lamp_q, walk_lamp_d;
`else
    logic unused_walk_req;
    assign unused_walk_req = walk_req_sync;
`endif

    // Reprogramming holds the timer armed so the load wait begins once it drops.
    assign timer_start = prg_sync_in | expired;

    phase_timer u_timer (
        .clk     (clk),
        .rst_n   (sys_reset_n),
        .start   (timer_start),
        .value   (interval_value),
        .tick    (one_hz_en),
        .expired (expired)
    );

    always_comb begin
        state_d = state_q;
        sens_d  = sens_q;
`ifdef TRAFFIC_WALK_REQ_EN
        walk_d  = walk_q | walk_req_sync;
`endif
        if (state_q == MAIN_GRN_BASE && sensor_sync) begin
            sens_d = 1'b1;
        end
        if (prg_sync_in) begin
            state_d = MAIN_GRN_BASE;
            sens_d  = 1'b0;
`ifdef TRAFFIC_WALK_REQ_EN
            walk_d  = 1'b0;
`endif
        end else if (expired) begin
            sens_d = 1'b0;
            case (state_q)
                MAIN_GRN_BASE: state_d = (sens_q || sensor_sync) ? MAIN_YEL : MAIN_GRN_EXT;
                MAIN_GRN_EXT:  state_d = MAIN_YEL;
                MAIN_YEL: begin
                    state_d = SIDE_GRN_BASE;
`ifdef TRAFFIC_WALK_REQ_EN
                    if (walk_q) begin
                        state_d = WALK;
                        // A request arriving on the entry cycle is kept for the next round.
                        walk_d  = walk_req_sync;
                    end
`endif
                end
                WALK:          state_d = SIDE_GRN_BASE;
                SIDE_GRN_BASE: state_d = sensor_sync ? SIDE_GRN_EXT : SIDE_YEL;
                SIDE_GRN_EXT:  state_d = SIDE_YEL;
                default:       state_d = MAIN_GRN_BASE;
            endcase
        end

        addr_d = state_addr(state_d);
        main_d = main_lamp(state_d);
        side_d = side_lamp(state_d);
        done_d = expired && !prg_sync_in;
`ifdef TRAFFIC_WALK_REQ_EN
        walk_lamp_d = (state_d == WALK);
`endif
    end

    always_ff @(posedge clk or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            state_q <= MAIN_GRN_BASE;
            sens_q  <= 1'b0;
            addr_q  <= BASE_ADD;
            main_q  <= LAMP_G;
            side_q  <= LAMP_R;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sens_q  <= sens_d;
            addr_q  <= addr_d;
            main_q  <= main_d;
            side_q  <= side_d;
            done_q  <= done_d;
        end
    end

`ifdef TRAFFIC_WALK_REQ_EN
    always_ff @(posedge clk or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            walk_q      <= 1'b0;
            walk_lamp_q <= 1'b0;
        end else begin
            walk_q      <= walk_d;
            walk_lamp_q <= walk_lamp_d;
        end
    end
    assign walk_lamp = walk_lamp_q;
`else
    assign walk_lamp = 1'b0;
`endif

    assign interval_address = addr_q;
    assign main_lights      = main_q;
    assign side_lights      = side_q;
    assign phase_done       = done_q;

endmodule
